// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port word RAM with bus locking.
// Define MEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority outside a lock.
module mem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned MAX_LOCK   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] p0_addr,
  input  logic        p0_rstrb,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  input  logic        p0_lock,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic [31:0] p1_addr,
  input  logic        p1_rstrb,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic          rsp_own_q, rsp_own_d;
  logic          rsp_rd_q, rsp_rd_d;
  logic          rsp_err_q, rsp_err_d;

  logic          req0, req1;
  logic          win_vld, win;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_wmask;
  logic          sel_rstrb, sel_lock, sel_oor;
  logic          own_lock, go;
  logic [CW-1:0] cnt_inc;

  assign req0 = p0_rstrb | (|p0_wmask);
  assign req1 = p1_rstrb | (|p1_wmask);

  // Reset also masks grants so nothing reaches the RAM while held.
  always_comb begin
    win_vld = 1'b0;
    win     = 1'b0;
    if (!resetn) begin
      win_vld = 1'b0;
    end else if (state_q == LOCKED) begin
      win     = owner_q;
      win_vld = owner_q ? req1 : req0;
    end else if (req0 && req1) begin
      win_vld = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      win     = 1'b0;
`else
      win     = ~last_gnt_q;
`endif
    end else if (req0) begin
      win_vld = 1'b1;
      win     = 1'b0;
    end else if (req1) begin
      win_vld = 1'b1;
      win     = 1'b1;
    end
  end

  assign p0_gnt = win_vld & ~win;
  assign p1_gnt = win_vld &  win;

  assign sel_addr  = win ? p1_addr  : p0_addr;
  assign sel_wdata = win ? p1_wdata : p0_wdata;
  assign sel_wmask = win ? p1_wmask : p0_wmask;
  assign sel_rstrb = win ? p1_rstrb : p0_rstrb;
  assign sel_lock  = win ? p1_lock  : p0_lock;
  assign own_lock  = owner_q ? p1_lock : p0_lock;
  assign sel_oor   = sel_addr >= 32'(ADDR_LIMIT);
  assign go        = win_vld & ~sel_oor;

  assign mem_addr  = go ? sel_addr  : 32'h0;
  assign mem_wdata = go ? sel_wdata : 32'h0;
  assign mem_wmask = go ? sel_wmask : 4'h0;
  assign mem_rstrb = go & sel_rstrb;

  assign p0_rvalid = rsp_vld_q & rsp_rd_q & ~rsp_own_q;
  assign p1_rvalid = rsp_vld_q & rsp_rd_q &  rsp_own_q;
  assign p0_err    = rsp_vld_q & rsp_err_q & ~rsp_own_q;
  assign p1_err    = rsp_vld_q & rsp_err_q &  rsp_own_q;
  assign p0_rdata  = (p0_rvalid & ~rsp_err_q) ? mem_rdata : 32'h0;
  assign p1_rdata  = (p1_rvalid & ~rsp_err_q) ? mem_rdata : 32'h0;

  assign cnt_inc = lock_cnt_q + CW'(1);

  always_comb begin
    rsp_vld_d  = win_vld;
    rsp_own_d  = win;
    rsp_rd_d   = sel_rstrb;
    rsp_err_d  = sel_oor;
    last_gnt_d = win_vld ? win : last_gnt_q;
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld && sel_lock && LOCK_EN) begin
          state_d    = LOCKED;
          owner_d    = win;
          lock_cnt_d = CW'(1);
        end
      end
      LOCKED: begin
        if (win_vld) lock_cnt_d = cnt_inc;
        // Forced release leaves last_gnt on the owner, so the peer wins next tie.
        if (!own_lock || (win_vld && cnt_inc == CW'(MAX_LOCK))) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_own_q  <= 1'b0;
      rsp_rd_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_own_q  <= rsp_own_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a port-indexed reference model.
module tb_mem_arbiter;

  localparam int AL = 1024;
  localparam int ML = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] a [2];
  logic        rs [2];
  logic [31:0] wd [2];
  logic [3:0]  wm [2];
  logic        lk [2];

  logic        p0_gnt, p0_rvalid, p0_err;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_LIMIT(AL), .MAX_LOCK(ML)) dut (
    .clk(clk), .resetn(resetn),
    .p0_addr(a[0]), .p0_rstrb(rs[0]), .p0_wdata(wd[0]),
    .p0_wmask(wm[0]), .p0_lock(lk[0]), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_addr(a[1]), .p1_rstrb(rs[1]), .p1_wdata(wd[1]),
    .p1_wmask(wm[1]), .p1_lock(lk[1]), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  // Word RAM seen by the DUT: registered read returns pre-write data.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= ram[mem_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b])
        ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mref [256];
  int          m_last, m_own, m_cnt, win;
  bit          m_lock;
  bit          pv, prd, perr;
  int          pown;
  logic [31:0] pdat;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit req(int k);
    return rs[k] || (wm[k] != 4'h0);
  endfunction

  task automatic model_reset();
    m_last = 1; m_lock = 0; m_cnt = 0; m_own = 0;
    pv = 0; prd = 0; perr = 0; pown = 0; pdat = 32'h0;
  endtask

  task automatic settle();
    logic [31:0] ea;
    bit inr, r0, r1;
    int w;
    @(negedge clk);
    if (!resetn) model_reset();
    win = -1;
    if (resetn) begin
      r0 = req(0);
      r1 = req(1);
      if (m_lock) win = req(m_own) ? m_own : -1;
      else if (r0 && r1) win = FIXED ? 0 : 1 - m_last;
      else if (r0) win = 0;
      else if (r1) win = 1;
    end
    w   = (win < 0) ? 0 : win;
    ea  = a[w];
    inr = (win >= 0) && (ea < AL);
    chk("p0_gnt", 32'(p0_gnt), 32'(win == 0));
    chk("p1_gnt", 32'(p1_gnt), 32'(win == 1));
    chk("mem_addr", mem_addr, inr ? ea : 32'h0);
    chk("mem_rstrb", 32'(mem_rstrb), 32'(inr && rs[w]));
    chk("mem_wdata", mem_wdata, inr ? wd[w] : 32'h0);
    chk("mem_wmask", 32'(mem_wmask), inr ? 32'(wm[w]) : 32'h0);
    chk("p0_rvalid", 32'(p0_rvalid), 32'(pv && prd && pown == 0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(pv && prd && pown == 1));
    chk("p0_rdata", p0_rdata, (pv && prd && pown == 0) ? pdat : 32'h0);
    chk("p1_rdata", p1_rdata, (pv && prd && pown == 1) ? pdat : 32'h0);
    chk("p0_err", 32'(p0_err), 32'(pv && perr && pown == 0));
    chk("p1_err", 32'(p1_err), 32'(pv && perr && pown == 1));
  endtask

  task automatic clk_edge();
    logic [31:0] ea;
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      pv = (win >= 0);
      if (pv) begin
        ea   = a[win];
        pown = win;
        prd  = rs[win];
        perr = (ea >= AL);
        pdat = perr ? 32'h0 : mref[ea[9:2]];
        if (!perr)
          for (int b = 0; b < 4; b++)
            if (wm[win][b]) mref[ea[9:2]][8*b +: 8] = wd[win][8*b +: 8];
      end
      if (m_lock) begin
        if (win >= 0) m_cnt++;
        if (!lk[m_own] || m_cnt >= ML) begin
          m_lock = 0;
          m_cnt  = 0;
        end
      end else if (win >= 0 && lk[win] && ML > 1) begin
        m_lock = 1; m_own = win; m_cnt = 1;
      end
      if (win >= 0) m_last = win;
    end
    #1;
  endtask

  task automatic clear();
    for (int k = 0; k < 2; k++) begin
      a[k] = 32'h0; rs[k] = 0; wd[k] = 32'h0; wm[k] = 4'h0; lk[k] = 0;
    end
  endtask

  task automatic rnd_port(int k);
    if ($urandom_range(0, 9) < 6) begin
      a[k]  = ($urandom_range(0, 7) == 0) ? 32'(AL + 4 * $urandom_range(0, 63))
                                          : 32'(4 * $urandom_range(0, 255));
      rs[k] = 1'($urandom_range(0, 1));
      wm[k] = 4'($urandom);
      wd[k] = $urandom;
      if (!rs[k] && wm[k] == 4'h0) rs[k] = 1;
    end else begin
      rs[k] = 0; wm[k] = 4'h0;
    end
    lk[k] = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    clear();
    model_reset();
    for (int i = 0; i < 256; i++) begin
      v = $urandom; ram[i] = v; mref[i] = v;
    end
    ram[4] = 32'hDEADBEEF; mref[4] = 32'hDEADBEEF;
    ram[8] = 32'h11223344; mref[8] = 32'h11223344;

    // Reset state
    settle();
    clk_edge();
    resetn = 1;

    // Both ports read every cycle: alternate, or all to p0 with fixed priority
    a[0] = 32'h40; rs[0] = 1; a[1] = 32'h44; rs[1] = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("t2_p0_gnt", 32'(p0_gnt), FIXED ? 32'h1 : 32'(i % 2 == 0));
      clk_edge();
    end
    clear();
    settle();
    clk_edge();

    // Single p0 read of word 4
    a[0] = 32'h10; rs[0] = 1;
    settle();
    chk("t1_gnt", 32'(p0_gnt), 32'h1);
    clk_edge();
    clear();
    settle();
    chk("t1_rvalid", 32'(p0_rvalid), 32'h1);
    chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
    chk("t1_p1_rvalid", 32'(p1_rvalid), 32'h0);
    clk_edge();

    // Byte write from p1, read back on p0
    a[1] = 32'h20; wd[1] = 32'h000000AA; wm[1] = 4'b0001;
    settle();
    chk("t3_wgnt", 32'(p1_gnt), 32'h1);
    clk_edge();
    clear();
    a[0] = 32'h20; rs[0] = 1;
    settle();
    clk_edge();
    clear();
    settle();
    chk("t3_rdata", p0_rdata, 32'h112233AA);
    clk_edge();

    // p1 locks for three grants while p0 waits
    a[1] = 32'h30; rs[1] = 1; lk[1] = 1;
    settle();
    chk("t4_enter", 32'(p1_gnt), 32'h1);
    clk_edge();
    a[0] = 32'h34; rs[0] = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t4_p0_wait", 32'(p0_gnt), 32'h0);
      clk_edge();
    end
    rs[1] = 0; lk[1] = 0;
    settle();
    chk("t4_p0_wait_drop", 32'(p0_gnt), 32'h0);
    clk_edge();
    settle();
    chk("t4_p0_after", 32'(p0_gnt), 32'h1);
    clk_edge();
    clear();

    // Lock held forever: forced release after MAX_LOCK grants
    a[1] = 32'h38; rs[1] = 1; lk[1] = 1;
    settle();
    clk_edge();
    a[0] = 32'h3C; rs[0] = 1;
    for (int i = 0; i < ML - 1; i++) begin
      settle();
      chk("t4_forced_wait", 32'(p1_gnt), 32'h1);
      clk_edge();
    end
    settle();
    chk("t4_forced_rel", 32'(p0_gnt), 32'h1);
    clk_edge();
    clear();
    settle();
    clk_edge();

    // Out-of-range read and write
    a[0] = 32'h400; rs[0] = 1;
    settle();
    chk("t5_gnt", 32'(p0_gnt), 32'h1);
    chk("t5_rstrb", 32'(mem_rstrb), 32'h0);
    clk_edge();
    clear();
    a[1] = 32'h400; wd[1] = 32'h55; wm[1] = 4'hF;
    settle();
    chk("t5_rvalid", 32'(p0_rvalid), 32'h1);
    chk("t5_rdata", p0_rdata, 32'h0);
    chk("t5_err", 32'(p0_err), 32'h1);
    chk("t5_wmask", 32'(mem_wmask), 32'h0);
    clk_edge();
    clear();
    settle();
    chk("t5_p1_err", 32'(p1_err), 32'h1);
    clk_edge();

    // Reset right after a granted read drops the response
    a[0] = 32'h10; rs[0] = 1; a[1] = 32'h14; rs[1] = 1;
    settle();
    clk_edge();
    resetn = 0;
    settle();
    chk("t6_rvalid", 32'(p0_rvalid), 32'h0);
    chk("t6_gnt", 32'(p0_gnt | p1_gnt), 32'h0);
    clk_edge();
    resetn = 1;
    settle();
    chk("t6_rvalid_after", 32'(p0_rvalid), 32'h0);
    chk("t6_tie", 32'(p0_gnt), 32'h1);
    clk_edge();
    clear();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++)
        if (win == k || !req(k)) rnd_port(k);
        else if ($urandom_range(0, 7) == 0) lk[k] = ~lk[k];
      settle();
      clk_edge();
    end
    clear();
    settle();
    clk_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
